csa_first_stage_pipe: RTL and testbench

CSA_FIRST_STAGE_PIPE -- requirements
Module: csa_first_stage_pipe

---
 rtl/csa_pkg.sv | 13 +
 rtl/csa_compress3.sv | 16 +
 rtl/csa_first_stage_pipe.sv | 149 ++++++++++++++
 tb/tb_csa_first_stage_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared width constant and buffer occupancy type for the CSA first stage.
// Build macro CSA_STAGE_SKID_EN (consumed by csa_first_stage_pipe) selects the 2-entry skid buffer.
package csa_pkg;

  localparam int CSA_WIDTH = 64;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/csa_compress3.sv
// rtl/csa_compress3.sv - combinational per-bit 3:2 compressor (sum = xor, carry = majority).
// Macro CSA_STAGE_SKID_EN has no effect here.
module csa_compress3 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_first_stage_pipe.sv
// rtl/csa_first_stage_pipe.sv - first carry-save stage: 3:2 compressor feeding an output buffer.
// CSA_STAGE_SKID_EN defined: 2-entry skid buffer with registered in_ready; undefined: single output register.
module csa_first_stage_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] si1,
  output logic [WIDTH-1:0] cyi,
  output logic             cin_o,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] w_si1;
  logic [WIDTH-1:0] w_cyi;
  logic             w_push;
  logic             w_pop;

  csa_compress3 #(.WIDTH(WIDTH)) u_compress3 (
    .a     (a),
    .b     (b),
    .c     (c),
    .sum   (w_si1),
    .carry (w_cyi)
  );

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

`ifdef CSA_STAGE_SKID_EN

  occ_t             r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_si1;
  logic [WIDTH-1:0] r_cyi;
  logic             r_cin;
  logic [WIDTH-1:0] r_si1_b;
  logic [WIDTH-1:0] r_cyi_b;
  logic             r_cin_b;

  // Head entry drives the outputs; the second entry only catches a triple
  // that arrives while the head is stalled, so in_ready never needs out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_si1       <= '0;
      r_cyi       <= '0;
      r_cin       <= 1'b0;
      r_si1_b     <= '0;
      r_cyi_b     <= '0;
      r_cin_b     <= 1'b0;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_push) begin
            r_si1       <= w_si1;
            r_cyi       <= w_cyi;
            r_cin       <= cin;
            r_out_valid <= 1'b1;
            r_state     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_si1 <= w_si1;
            r_cyi <= w_cyi;
            r_cin <= cin;
          end else if (w_push) begin
            r_si1_b    <= w_si1;
            r_cyi_b    <= w_cyi;
            r_cin_b    <= cin;
            r_in_ready <= 1'b0;
            r_state    <= OCC_FULL;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_si1      <= r_si1_b;
            r_cyi      <= r_cyi_b;
            r_cin      <= r_cin_b;
            r_in_ready <= 1'b1;
            r_state    <= OCC_ONE;
          end
        end
        default: begin
          r_state     <= OCC_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign si1       = r_si1;
  assign cyi       = r_cyi;
  assign cin_o     = r_cin;
  assign occ       = r_state;

`else

  logic             r_out_valid;
  logic [WIDTH-1:0] r_si1;
  logic [WIDTH-1:0] r_cyi;
  logic             r_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_si1       <= '0;
      r_cyi       <= '0;
      r_cin       <= 1'b0;
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_si1       <= w_si1;
      r_cyi       <= w_cyi;
      r_cin       <= cin;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign si1       = r_si1;
  assign cyi       = r_cyi;
  assign cin_o     = r_cin;
  assign occ       = {1'b0, r_out_valid};

`endif

endmodule

// File: tb/tb_csa_first_stage_pipe.sv
// tb/tb_csa_first_stage_pipe.sv - scoreboard bench for csa_first_stage_pipe.
// Works with CSA_STAGE_SKID_EN defined (capacity 2) or undefined (capacity 1).
module tb_csa_first_stage_pipe;

  localparam int W = 64;
`ifdef CSA_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  c = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  si1;
  logic [W-1:0]  cyi;
  logic          cin_o;
  logic [1:0]    occ;

  logic          man_ready = 1'b0;
  logic          rnd_ready = 1'b0;
  bit            rand_phase = 1'b0;
  assign out_ready = rand_phase ? rnd_ready : man_ready;

  always #5 clk = ~clk;

  csa_first_stage_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .si1       (si1),
    .cyi       (cyi),
    .cin_o     (cin_o),
    .occ       (occ)
  );

  typedef struct {
    logic [W+1:0] sum;
    bit           vec;
    logic [W-1:0] e_si1;
    logic [W-1:0] e_cyi;
    logic         e_cin;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   max_occ = 0;

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int val);
    n_total++;
    $display("FAIL %s: got %0d expected completion", name, val);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] tc,
                      input logic tcin, input bit vec, input logic [W-1:0] esi,
                      input logic [W-1:0] ecy, input logic ecin, input logic [W+1:0] esum);
    int   waited = 0;
    bit   done = 1'b0;
    exp_t e;
    a = ta; b = tb; c = tc; cin = tcin; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.sum = esum; e.vec = vec; e.e_si1 = esi; e.e_cyi = ecy; e.e_cin = ecin;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited >= 200) begin
          fail_now("send_timeout", waited);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [W-1:0] ta, tb, tc;
    logic         tcin;
    ta = {$urandom, $urandom};
    tb = {$urandom, $urandom};
    tc = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) ta = '1;
    if ($urandom_range(0, 7) == 0) tb = '1;
    tcin = 1'($urandom_range(0, 1));
    send(ta, tb, tc, tcin, 1'b0, '0, '0, 1'b0,
         (W+2)'(ta) + (W+2)'(tb) + (W+2)'(tc) + (W+2)'(tcin));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  bit           prev_stall = 1'b0;
  logic [W-1:0] p_si1, p_cyi;
  logic         p_cin;
  exp_t         m_e;
  logic [W+1:0] m_got;

  always @(negedge clk) begin
    if (int'(occ) > max_occ) max_occ = int'(occ);
    if (prev_stall && out_valid) begin
      chk("hold_si1", si1, p_si1);
      chk("hold_cyi", cyi, p_cyi);
      chk("hold_cin", cin_o, p_cin);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        fail_now("unexpected_output", 0);
      end else begin
        m_e = q.pop_front();
        m_got = (W+2)'(si1) + ((W+2)'(cyi) << 1) + (W+2)'(cin_o);
        chk("sum", m_got, m_e.sum);
        if (m_e.vec) begin
          chk("vec_si1", si1, m_e.e_si1);
          chk("vec_cyi", cyi, m_e.e_cyi);
          chk("vec_cin", cin_o, m_e.e_cin);
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    p_si1 = si1; p_cyi = cyi; p_cin = cin_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_first;
    bit got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occ", occ, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_si1", si1, 0);
    chk("rst_cyi", cyi, 0);
    chk("rst_cin_o", cin_o, 0);
    rst_n = 1'b1;

    man_ready = 1'b1;
    send(64'd1, 64'd1, 64'd1, 1'b0, 1'b1, 64'd1, 64'd1, 1'b0, 66'd3);
    chk("lat_valid", out_valid, 1);
    chk("lat_si1", si1, 1);
    chk("lat_cyi", cyi, 1);
    chk("lat_cin", cin_o, 0);
    idle(2);

    send('1, 64'd1, 64'd0, 1'b1, 1'b1, {{63{1'b1}}, 1'b0}, 64'd1, 1'b1,
         66'h1_0000_0000_0000_0001);
    idle(2);

    man_ready = 1'b0;
    fork
      begin
        send(64'd5, 64'd3, 64'd0, 1'b0, 1'b1, 64'd6, 64'd1, 1'b0, 66'd8);
        send(64'd10, 64'd12, 64'd6, 1'b1, 1'b1, 64'd0, 64'd14, 1'b1, 66'd29);
        send(64'hFF, 64'hF0, 64'h0F, 1'b0, 1'b1, 64'h00, 64'hFF, 1'b0, 66'd510);
      end
      begin
        seen_first = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          @(negedge clk);
          if (occ != 0 && seen_first == 0) seen_first = int'(occ);
          if (int'(occ) == CAP) got = 1'b1;
        end
        chk("fill_first_occ", seen_first, 1);
        chk("fill_reached", got, 1);
        chk("full_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("held_occ", occ, CAP);
        chk("held_valid", out_valid, 1);
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(negedge clk);
        chk("ready_follow", in_ready, (CAP == 1) ? 1 : 0);
        @(posedge clk); #1;
      end
    join
    idle(4);
    chk("burst_drained", q.size(), 0);

    man_ready = 1'b0;
    for (int i = 0; i < CAP; i++) send_rand();
    @(negedge clk);
    chk("pre_rst_occ", occ, CAP);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", in_ready, 1);
    send(64'd7, 64'd7, 64'd7, 1'b1, 1'b1, 64'd7, 64'd7, 1'b1, 66'd22);
    man_ready = 1'b1;
    idle(3);
    chk("post_rst_drained", q.size(), 0);

    rand_phase = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      idle($urandom_range(0, 1));
      send_rand();
    end
    man_ready = 1'b1;
    rand_phase = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("final_drained", q.size(), 0);
    @(negedge clk);
    chk("final_out_valid", out_valid, 0);
    chk("max_occ", max_occ, CAP);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
